dircc_send_handler: RTL
=======================

# dircc_send_handler

Consumer of the per-device ready-to-send flags in the DiRCC thread pipeline. It accepts one `rts_ready` port mask per thread context and serialises it into one outgoing packet per set bit, lowest port first, over a valid/ready transmit interface. When the whole mask has gone out, it issues a single write-back so the device state can be marked sent. The block sits between the RTS computation stage and the node's output packet FIFO/NoC injector.

## Interface
- `ADDRESS_MEM_WIDTH`, 32, width of the thread-context index
- `PAYLOAD_WIDTH`, 32, width of the message payload
- `DEVICE_ID`, 0, source device ID placed in every packet
- `clk`  in  1  single clock, all logic rising-edge
- `reset`  in  1  reset, synchronous and active-high
- `rts_valid`  in  1  request present on `address`/`rts_ready`/`payload_in`
- `rts_accept`  out  1  handler can take a request this cycle
- `address`  in  ADDRESS_MEM_WIDTH  thread context the request belongs to
- `rts_ready`  in  32  port mask, bit n set = send on output port n
- `payload_in`  in  PAYLOAD_WIDTH  payload to send on every port of this request
- `tx_valid`  out  1  packet valid
- `tx_ready`  in  1  downstream accepts packet
- `tx_port`  out  5  output port index of current packet
- `tx_src_device`  out  32  equals DEVICE_ID
- `tx_src_address`  out  ADDRESS_MEM_WIDTH  captured `address`
- `tx_payload`  out  PAYLOAD_WIDTH  captured `payload_in`
- `sent_we`  out  1  write-back request
- `sent_ack`  in  1  write-back accepted
- `sent_address`  out  ADDRESS_MEM_WIDTH  context to mark sent
- `sent_port_mask`  out  32  mask of ports actually sent
- `busy`  out  1  high in any state other than IDLE
- `packet_count`  out  16  total packets handshaken since reset, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, SEND, WRITEBACK.
- IDLE: `rts_accept`=1. On `rts_valid`=1 and `rts_ready`≠0, capture address, mask (as remaining mask and as original mask), and payload, then go to SEND. A request with `rts_valid`=1 and `rts_ready`=0 is consumed (accepted) with no other effect and the FSM stays in IDLE.
- SEND: `tx_valid`=1. `tx_port` = index of the lowest set bit of the remaining mask, through a combinational priority encoder on the registered mask. All tx fields are held stable until `tx_ready`.
  - On handshake (`tx_valid`&&`tx_ready`): clear that bit and increment `packet_count`.
  - If the remaining mask becomes 0, go to WRITEBACK. Otherwise stay in SEND with the next port.
- WRITEBACK: `sent_we`=1, `sent_address` = captured address, `sent_port_mask` = original captured mask. Hold until `sent_ack`, then go to IDLE.
- `rts_accept`=0 in SEND and WRITEBACK. Input changes while not accepting are ignored.
- `tx_ready` outside SEND and `sent_ack` outside WRITEBACK are ignored.

## Timing
- Reset (synchronous, any state, including mid-packet): the next state is IDLE and every register clears.
  - Output values: `tx_valid`=0, `sent_we`=0, `busy`=0, `packet_count`=0, `rts_accept`=1 after the reset edge.
  - All data outputs are 0.
  - An in-flight packet or write-back is abandoned.
- Accept at edge k → `tx_valid`=1 from cycle k+1. There are no bubbles between consecutive ports: the handshake at edge j presents the next port in cycle j+1.
- Last handshake at edge j → `sent_we`=1 in cycle j+1. `sent_ack` at edge m → IDLE and `rts_accept`=1 in cycle m+1.
- Minimum occupancy for an N-bit mask with `tx_ready` and `sent_ack` held high: N+1 cycles after accept.
- `packet_count` is a 16-bit modulo counter. It updates on the same edge as the handshake.

## Test plan
- Single port: `rts_ready`=0x1, `address`=5, `payload_in`=0xA5, `tx_ready`=1.
  - One packet is sent: port 0, src_address 5, payload 0xA5, cycle k+1.
  - `sent_we` follows in cycle k+2 with mask 0x1.
  - `packet_count`=1.
- Multi-port ordering: `rts_ready`=0x8000_0005.
  - Packets go out on ports 0, 2, then 31, in consecutive cycles.
  - `sent_port_mask`=0x8000_0005.
- Backpressure: mask 0x6, `tx_ready` low for 3 cycles on each packet.
  - tx fields stay stable while stalled.
  - Exactly 2 packets are sent.
  - `rts_accept` stays 0 until `sent_ack`.
- Zero mask and busy ignore:
  - `rts_valid` with `rts_ready`=0: no packet, no write-back.
  - `rts_valid` pulsed during SEND: no effect on the current request.
- Reset mid-operation: assert `reset` while stalled in SEND, and again in WRITEBACK.
  - Next cycle: `tx_valid`=0, `sent_we`=0, `packet_count`=0, `rts_accept`=1.
- Counter wrap: 65536 single-port requests leave `packet_count` at 0 after the last one.

Source files
------------

// File: rtl/dircc_send_handler.sv
// dircc_send_handler: serialises a per-context RTS port mask into one
// packet per set bit (lowest port first), then issues a sent write-back.
module dircc_send_handler #(
  parameter int          ADDRESS_MEM_WIDTH = 32,
  parameter int          PAYLOAD_WIDTH     = 32,
  parameter logic [31:0] DEVICE_ID         = 32'd0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rts_valid,
  output logic                         rts_accept,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic [31:0]                  rts_ready,
  input  logic [PAYLOAD_WIDTH-1:0]     payload_in,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [4:0]                   tx_port,
  output logic [31:0]                  tx_src_device,
  output logic [ADDRESS_MEM_WIDTH-1:0] tx_src_address,
  output logic [PAYLOAD_WIDTH-1:0]     tx_payload,
  output logic                         sent_we,
  input  logic                         sent_ack,
  output logic [ADDRESS_MEM_WIDTH-1:0] sent_address,
  output logic [31:0]                  sent_port_mask,
  output logic                         busy,
  output logic [15:0]                  packet_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WRITEBACK = 2'd2
  } state_e;

  state_e                       state_q;
  logic [ADDRESS_MEM_WIDTH-1:0] addr_q;
  logic [31:0]                  rem_q;
  logic [31:0]                  orig_q;
  logic [PAYLOAD_WIDTH-1:0]     payload_q;
  logic [15:0]                  cnt_q;
  logic [4:0]                   port_d;
  logic [31:0]                  rem_d;

  // Lowest set bit of the remaining mask selects the current port
  always_comb begin
    port_d = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (rem_q[i]) port_d = 5'(i);
    end
  end

  // Remaining mask with its lowest set bit cleared
  assign rem_d = rem_q & (rem_q - 32'd1);

  // Control FSM and all captured request state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      orig_q    <= '0;
      payload_q <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rts_valid && (rts_ready != 32'd0)) begin
            addr_q    <= address;
            rem_q     <= rts_ready;
            orig_q    <= rts_ready;
            payload_q <= payload_in;
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            rem_q <= rem_d;
            cnt_q <= cnt_q + 16'd1;
            if (rem_d == 32'd0) state_q <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          if (sent_ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rts_accept     = (state_q == IDLE);
  assign tx_valid       = (state_q == SEND);
  assign sent_we        = (state_q == WRITEBACK);
  assign busy           = (state_q != IDLE);
  assign tx_port        = port_d;
  assign tx_src_device  = DEVICE_ID;
  assign tx_src_address = addr_q;
  assign tx_payload     = payload_q;
  assign sent_address   = addr_q;
  assign sent_port_mask = orig_q;
  assign packet_count   = cnt_q;

endmodule
